fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/baud_counter.sv | 43 ++++
 rtl/fifo_uart_tx.sv | 106 ++++++++++
 tb/tb_fifo_uart_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | uart_pkg: shared TX state type and default framing constants |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
package uart_pkg;

  localparam int unsigned c_CLKS_PER_BIT = 434;  // 50 MHz / 115200
  localparam int unsigned c_DW           = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/baud_counter.sv
`default_nettype none
// +--------------------------------------------------------------+
// | baud_counter: 0..CLKS_PER_BIT-1 counter with bit-end tick    |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = c_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned          CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]        c_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == c_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------+
// | fifo_uart_tx: pops bytes from a FIFO and sends them as 8N1   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = c_CLKS_PER_BIT,
  parameter int unsigned DW           = c_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty_i,
  input  logic [DW-1:0] fifo_data_i,
  output logic          fifo_rd_en_o,
  output logic          tx_o,
  output logic          busy_o,
  output logic [15:0]   frames_o
);

  localparam int unsigned   BW         = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] c_LAST_BIT = BW'(DW - 1);

  tx_state_t     state_q, state_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [15:0]   frames_q, frames_d;
  logic          tx_q, tx_d;
  logic          baud_tick;
  logic          baud_clear;
  logic          baud_en;

  assign baud_en    = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign baud_clear = (state_d != state_q);

  baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (baud_clear),
    .enable_i (baud_en),
    .tick_o   (baud_tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    frames_d = frames_q;
    case (state_q)
      IDLE:  if (!fifo_empty_i) state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data_i;
        bit_d   = '0;
        state_d = START;
      end
      START: if (baud_tick) state_d = DATA;
      DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == c_LAST_BIT) state_d = STOP;
          else                     bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d  = IDLE;
          frames_d = frames_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so tx_o lines up with state_q.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      frames_q <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      frames_q <= frames_d;
      tx_q     <= tx_d;
    end
  end

  assign fifo_rd_en_o = (state_q == IDLE) && !fifo_empty_i && !rst;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != IDLE);
  assign frames_o     = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_fifo_uart_tx: FIFO model + line-level receiver for 8N1 TX |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int LIMIT = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty_i = 1'b1;
  logic [7:0]  fifo_data_i = 8'h00;
  logic        fifo_rd_en_o;
  logic        tx_o;
  logic        busy_o;
  logic [15:0] frames_o;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          pops = 0;
  logic [15:0] exp_frames = 16'h0000;
  logic [7:0]  fifo_q[$];
  logic [7:0]  sent_q[$];
  int          pop_cyc_q[$];
  logic [7:0]  pop_b;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DW           (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .frames_o     (frames_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read FIFO: data appears the cycle after a pop.
  always @(posedge clk) begin
    if (fifo_rd_en_o === 1'b1) begin
      check("pop_while_nonempty", fifo_empty_i, 0);
      check("pop_outside_reset", rst, 0);
      if (fifo_q.size() > 0) begin
        pop_b = fifo_q.pop_front();
        fifo_data_i  <= pop_b;
        pop_cyc_q.push_back(cyc);
        pops++;
        fifo_empty_i <= (fifo_q.size() == 0);
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    sent_q.push_back(b);
    fifo_empty_i = 1'b0;
  endtask

  // Waits for a start bit, then compares every line sample against the ideal 8N1 frame.
  task automatic rx_check(output int fall_c, output int end_c);
    int         t;
    int         mism;
    int         n;
    int         pc;
    logic       lvl;
    logic [7:0] eb;
    logic [7:0] rb;
    t = 0;
    while (tx_o !== 1'b0 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check("rx_start_seen", t < LIMIT, 1);
    fall_c = cyc;
    end_c  = cyc;
    if (t >= LIMIT) return;
    check("rx_sent_avail", sent_q.size() != 0, 1);
    if (sent_q.size() == 0) return;
    eb = sent_q.pop_front();
    pc = (pop_cyc_q.size() != 0) ? pop_cyc_q.pop_front() : -1000;
    check("rx_pop_to_start", cyc - pc, 2);
    mism = 0;
    rb   = 8'h00;
    for (int k = 0; k < 10 * CPB; k++) begin
      n = k / CPB;
      if (n == 0)      lvl = 1'b0;
      else if (n == 9) lvl = 1'b1;
      else             lvl = eb[n-1];
      if (tx_o !== lvl || busy_o !== 1'b1) mism++;
      if (n >= 1 && n <= 8 && (k % CPB) == CPB / 2) rb[n-1] = tx_o;
      @(negedge clk);
    end
    check("rx_line_mismatches", mism, 0);
    check("rx_byte", rb, eb);
    check("rx_idle_after_stop", busy_o, 0);
    end_c = cyc;
    exp_frames = exp_frames + 16'd1;
    check("frames", frames_o, exp_frames);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f1, e1, f2, e2, p0, t, rdh, txl, bh, nb;

    repeat (3) @(negedge clk);
    check("reset_tx", tx_o, 1);
    check("reset_rd_en", fifo_rd_en_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_frames", frames_o, 0);
    rst = 1'b0;

    rdh = 0; txl = 0; bh = 0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en_o !== 1'b0) rdh++;
      if (tx_o !== 1'b1) txl++;
      if (busy_o !== 1'b0) bh++;
    end
    check("empty_rd_en_cycles", rdh, 0);
    check("empty_tx_low_cycles", txl, 0);
    check("empty_busy_cycles", bh, 0);

    // Abort 0x3C in data bit 3 with the next byte already waiting.
    @(negedge clk);
    push(8'h3C);
    push(8'h5A);
    t = 0;
    while (tx_o !== 1'b0 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check("abort_start_seen", t < LIMIT, 1);
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    check("abort_bit3_level", tx_o, 1);
    check("abort_busy_before", busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx_high", tx_o, 1);
    check("abort_busy", busy_o, 0);
    check("abort_frames", frames_o, exp_frames);
    check("abort_rd_en_in_rst", fifo_rd_en_o, 0);
    @(negedge clk);
    check("abort_rd_en_in_rst_idle", fifo_rd_en_o, 0);
    rst = 1'b0;
    void'(sent_q.pop_front());
    void'(pop_cyc_q.pop_front());
    rx_check(f1, e1);

    p0 = pops;
    push(8'hA5);
    rx_check(f1, e1);
    check("single_pop_count", pops - p0, 1);

    p0 = pops;
    push(8'h00);
    push(8'hFF);
    rx_check(f1, e1);
    rx_check(f2, e2);
    check("b2b_gap", f2 - e1, 2);
    check("b2b_pop_count", pops - p0, 2);

    for (int burst = 0; burst < 4; burst++) begin
      nb = $urandom_range(1, 3);
      p0 = pops;
      for (int i = 0; i < nb; i++) push(8'($urandom));
      for (int i = 0; i < nb; i++) begin
        rx_check(f2, e2);
        if (i > 0) check("rand_gap", f2 - e1, 2);
        e1 = e2;
      end
      check("rand_pop_count", pops - p0, nb);
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end

    // Hold the forced value across an edge so the register itself holds 0xFFFF.
    @(negedge clk);
    force dut.frames_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.frames_q;
    check("wrap_preload", frames_o, 16'hFFFF);
    exp_frames = 16'hFFFF;
    push(8'hC3);
    rx_check(f1, e1);
    check("wrap_zero", frames_o, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
